// File: rtl/sevseg_scan_driver_if.sv
// Display bus: producer-side nibbles/masks in, multiplexed anode/cathode drive out.
// Outputs are registered in the driver; there is no backpressure, the scan free-runs.
interface sevseg_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    en;
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   blink_en;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   anode_n;
    logic [7:0]              seg_n;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_done;

    modport master (
        output en, data_in, dp_in, digit_en, blink_en, blank_lz,
        input  anode_n, seg_n, digit_idx, frame_done
    );

    modport slave (
        input  en, data_in, dp_in, digit_en, blink_en, blank_lz,
        output anode_n, seg_n, digit_idx, frame_done
    );
endinterface

// File: rtl/sevseg_scan_driver.sv
// Self-scanning common-anode 7-segment multiplexer with snapshot, LZ blanking, blink and dead time.
// Pins lag the prescaler/digit state by one clk; no backpressure, en=0 darkens and freezes the scan.
module sevseg_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_DIV      = 100000,
    parameter int DEAD         = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    sevseg_scan_driver_if.slave        dsp
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]           presc_q;
    logic [IDX_W-1:0]        idx_q;
    logic [BW-1:0]           frame_cnt_q;
    logic                    blink_q;
    logic                    frame_done_q;
    logic [NUM_DIGITS-1:0]   anode_n_q, anode_n_d;
    logic [7:0]              seg_n_q, seg_n_d;

    logic [4*NUM_DIGITS-1:0] snap_dat_q;
    logic [NUM_DIGITS-1:0]   snap_dp_q;
    logic [NUM_DIGITS-1:0]   snap_den_q;
    logic [NUM_DIGITS-1:0]   snap_bli_q;
    logic                    snap_blz_q;

    logic                    tick, wrap, lit, all_zero;
    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lz_blank;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign tick = dsp.en && (presc_q == PW'(CLK_DIV - 1));
    assign wrap = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

    // A digit is a leading zero when it and everything above it is zero; digit 0 always shows.
    always_comb begin
        all_zero = 1'b1;
        lz_blank = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib[i] = snap_dat_q[4*i +: 4];
        end
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero    = all_zero && (nib[i] == 4'h0);
            lz_blank[i] = snap_blz_q && all_zero && (i != 0);
        end
    end

    always_comb begin
        lit = dsp.en && (presc_q >= PW'(DEAD)) && snap_den_q[idx_q] && !lz_blank[idx_q]
              && !(snap_bli_q[idx_q] && blink_q);
        anode_n_d = '1;
        seg_n_d   = 8'hFF;
        if (lit) begin
            anode_n_d = ~(NUM_DIGITS'(1) << idx_q);
            seg_n_d   = {~snap_dp_q[idx_q], hex7(nib[idx_q])};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            frame_cnt_q  <= '0;
            blink_q      <= 1'b0;
            frame_done_q <= 1'b0;
            anode_n_q    <= '1;
            seg_n_q      <= 8'hFF;
            snap_dat_q   <= '0;
            snap_dp_q    <= '0;
            snap_den_q   <= '0;
            snap_bli_q   <= '0;
            snap_blz_q   <= 1'b0;
        end else begin
            anode_n_q    <= anode_n_d;
            seg_n_q      <= seg_n_d;
            frame_done_q <= wrap;
            if (dsp.en) begin
                presc_q <= tick ? '0 : presc_q + PW'(1);
            end
            if (tick) begin
                idx_q <= wrap ? '0 : idx_q + IDX_W'(1);
            end
            // Inputs are only sampled between frames (or while idle) so a frame never tears.
            if (wrap || !dsp.en) begin
                snap_dat_q <= dsp.data_in;
                snap_dp_q  <= dsp.dp_in;
                snap_den_q <= dsp.digit_en;
                snap_bli_q <= dsp.blink_en;
                snap_blz_q <= dsp.blank_lz;
            end
            if (wrap) begin
                if (frame_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                    frame_cnt_q <= '0;
                    blink_q     <= ~blink_q;
                end else begin
                    frame_cnt_q <= frame_cnt_q + BW'(1);
                end
            end
        end
    end

    assign dsp.anode_n    = anode_n_q;
    assign dsp.seg_n      = seg_n_q;
    assign dsp.digit_idx  = idx_q;
    assign dsp.frame_done = frame_done_q;
endmodule
